prog_loader: RTL and testbench

//  Parametrised UART program loader; replaces the ad-hoc LOAD-mode byte packing in the core top.

---
 rtl/prog_loader.sv | 212 +++++++++++++++++++++
 tb/tb_prog_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: UART program loader.
// Packs received bytes into WORD_BYTES-wide words and writes them to
// instruction memory from word address 0 upward. With USE_HEADER=1 a load is
// a framed transfer: a little-endian word count, the payload, and one XOR
// checksum byte. With USE_HEADER=0 the load is a raw stream ended by STOP.
// done/error are held until the next START or RST so the core top can decide
// whether to switch to EXEC.
module prog_loader #(
  parameter int ADDR_WIDTH = 17,
  parameter int WORD_BYTES = 4,
  parameter int BIG_ENDIAN = 0,
  parameter int USE_HEADER = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic                    STOP,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_wdata,
  output logic                    mem_we,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [ADDR_WIDTH:0]     words_loaded
);

  localparam int W  = 8 * WORD_BYTES;
  localparam int NW = ADDR_WIDTH + 1;
  localparam int CW = $clog2(WORD_BYTES) + 1;

  localparam bit RAW = (USE_HEADER == 0);
  localparam bit BE  = (BIG_ENDIAN != 0);

  // Index of the byte that completes a word.
  localparam logic [CW-1:0] LAST = CW'(WORD_BYTES - 1);
  // Memory capacity in words; a raw stream may not complete a word at this index.
  localparam logic [NW-1:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  // Largest header word count accepted (the whole memory).
  localparam logic [64:0] LIMIT = 65'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_d;

  // Byte-packing stage registers.
  logic [CW-1:0] byte_cnt_p0;
  logic [W-1:0]  word_p0;
  logic [7:0]    checksum_p0;
  logic [NW-1:0] n_words;

  // Combinational decode of the current byte.
  logic          last_byte;
  logic [CW-1:0] data_lane;
  logic [W-1:0]  packed_w;
  logic [W-1:0]  hdr_word;
  logic [63:0]   hdr_n;
  logic          hdr_too_big;
  logic          hdr_zero;
  logic          full_word;
  logic          flush;
  logic          wr_issue;
  logic [W-1:0]  wr_word;

  // Replace one byte lane of a word with a new byte.
  function automatic logic [W-1:0] put_lane(input logic [W-1:0] w,
                                            input logic [7:0]   b,
                                            input logic [CW-1:0] lane);
    logic [W-1:0] r;
    r = w;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (lane == CW'(i)) r[8*i +: 8] = b;
    end
    return r;
  endfunction

  // Zero-extend a header word so it can be compared against the capacity
  // regardless of how W relates to ADDR_WIDTH.
  function automatic logic [63:0] widen(input logic [W-1:0] w);
    return 64'(w);
  endfunction

  // Next-state and write-issue decode; every output has a default first.
  always_comb begin
    state_d     = state;
    wr_issue    = 1'b0;
    wr_word     = word_p0;
    full_word   = 1'b0;
    flush       = 1'b0;
    last_byte   = (byte_cnt_p0 == LAST);
    data_lane   = BE ? (LAST - byte_cnt_p0) : byte_cnt_p0;
    packed_w    = put_lane(word_p0, rx_data, data_lane);
    hdr_word    = put_lane(word_p0, rx_data, byte_cnt_p0);
    hdr_n       = widen(hdr_word);
    hdr_too_big = ({1'b0, hdr_n} > LIMIT);
    hdr_zero    = (hdr_n == 64'd0);

    if (START) begin
      state_d = RAW ? S_DATA : S_HEADER;
    end else begin
      case (state)
        S_HEADER: begin
          if (rx_valid && last_byte) begin
            if (hdr_too_big)   state_d = S_ERR;
            else if (hdr_zero) state_d = S_CHECK;
            else               state_d = S_DATA;
          end
        end
        S_DATA: begin
          full_word = rx_valid && last_byte;
          // A STOP in the same cycle as a byte applies after that byte is packed.
          flush     = RAW && STOP;
          if (full_word || (flush && (rx_valid || byte_cnt_p0 != '0))) begin
            if (RAW && words_loaded == FULL) begin
              state_d = S_ERR;
            end else begin
              wr_issue = 1'b1;
              wr_word  = rx_valid ? packed_w : word_p0;
              if (!RAW && full_word && (words_loaded + 1'b1 == n_words))
                state_d = S_CHECK;
              else if (flush)
                state_d = S_DONE;
            end
          end else if (flush) begin
            state_d = S_DONE;
          end
        end
        S_CHECK: begin
          if (rx_valid) state_d = (rx_data == checksum_p0) ? S_DONE : S_ERR;
        end
        default: state_d = state;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_d;
  end

  // ---- stage p0: byte packing, header capture, checksum ----
  // ---- stage p1: memory write port and word counter ----
  // Datapath: collect bytes, issue word writes, track count and checksum.
  always_ff @(posedge CLK) begin
    if (RST) begin
      byte_cnt_p0  <= '0;
      word_p0      <= '0;
      checksum_p0  <= '0;
      n_words      <= '0;
      words_loaded <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_we       <= 1'b0;
    end else if (START) begin
      byte_cnt_p0  <= '0;
      word_p0      <= '0;
      checksum_p0  <= '0;
      n_words      <= '0;
      words_loaded <= '0;
      mem_we       <= 1'b0;
    end else begin
      mem_we <= wr_issue;
      if (wr_issue) begin
        mem_addr     <= words_loaded[ADDR_WIDTH-1:0];
        mem_wdata    <= wr_word;
        words_loaded <= words_loaded + 1'b1;
      end
      case (state)
        S_HEADER: begin
          if (rx_valid) begin
            if (last_byte) begin
              byte_cnt_p0 <= '0;
              word_p0     <= '0;
              n_words     <= NW'(hdr_n);
            end else begin
              byte_cnt_p0 <= byte_cnt_p0 + 1'b1;
              word_p0     <= hdr_word;
            end
          end
        end
        S_DATA: begin
          if (rx_valid) checksum_p0 <= checksum_p0 ^ rx_data;
          // Clearing on every write keeps unfilled lanes of a flushed word zero.
          if (wr_issue || state_d != S_DATA) begin
            byte_cnt_p0 <= '0;
            word_p0     <= '0;
          end else if (rx_valid) begin
            byte_cnt_p0 <= byte_cnt_p0 + 1'b1;
            word_p0     <= packed_w;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status flags decode directly from the state register.
  assign busy  = (state == S_HEADER) || (state == S_DATA) || (state == S_CHECK);
  assign done  = (state == S_DONE);
  assign error = (state == S_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: four instances (LE framed, BE framed,
// 2-bit-address framed, 2-bit-address raw) share one input bus; one is
// observed at a time. Expected memory writes are queued before stimulus and
// popped as the observed instance raises mem_we.
module tb_prog_loader;

  localparam int NV = 11;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic [7:0] rx_data;
  logic       rx_valid;
  int         sel;

  logic [16:0] a0, a1;
  logic [1:0]  a2, a3;
  logic [31:0] d0, d1, d2, d3;
  logic        we0, we1, we2, we3;
  logic        b0, b1, b2, b3;
  logic        dn0, dn1, dn2, dn3;
  logic        e0, e1, e2, e3;
  logic [17:0] wl0, wl1;
  logic [2:0]  wl2, wl3;

  logic [16:0] o_addr;
  logic [31:0] o_wdata;
  logic        o_we, o_busy, o_done, o_err;
  logic [17:0] o_wl;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_WIDTH(17), .WORD_BYTES(4), .BIG_ENDIAN(0), .USE_HEADER(1)) u_le (
    .CLK(clk), .RST(rst), .START(start), .STOP(stop), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_addr(a0), .mem_wdata(d0), .mem_we(we0), .busy(b0), .done(dn0), .error(e0),
    .words_loaded(wl0));

  prog_loader #(.ADDR_WIDTH(17), .WORD_BYTES(4), .BIG_ENDIAN(1), .USE_HEADER(1)) u_be (
    .CLK(clk), .RST(rst), .START(start), .STOP(stop), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_addr(a1), .mem_wdata(d1), .mem_we(we1), .busy(b1), .done(dn1), .error(e1),
    .words_loaded(wl1));

  prog_loader #(.ADDR_WIDTH(2), .WORD_BYTES(4), .BIG_ENDIAN(0), .USE_HEADER(1)) u_small (
    .CLK(clk), .RST(rst), .START(start), .STOP(stop), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_addr(a2), .mem_wdata(d2), .mem_we(we2), .busy(b2), .done(dn2), .error(e2),
    .words_loaded(wl2));

  prog_loader #(.ADDR_WIDTH(2), .WORD_BYTES(4), .BIG_ENDIAN(0), .USE_HEADER(0)) u_raw (
    .CLK(clk), .RST(rst), .START(start), .STOP(stop), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_addr(a3), .mem_wdata(d3), .mem_we(we3), .busy(b3), .done(dn3), .error(e3),
    .words_loaded(wl3));

  // Route the selected instance to the observed signals.
  always_comb begin
    o_addr = '0; o_wdata = '0; o_we = 1'b0; o_busy = 1'b0; o_done = 1'b0; o_err = 1'b0; o_wl = '0;
    case (sel)
      0: begin o_addr = a0; o_wdata = d0; o_we = we0; o_busy = b0; o_done = dn0; o_err = e0; o_wl = wl0; end
      1: begin o_addr = a1; o_wdata = d1; o_we = we1; o_busy = b1; o_done = dn1; o_err = e1; o_wl = wl1; end
      2: begin o_addr = {15'd0, a2}; o_wdata = d2; o_we = we2; o_busy = b2; o_done = dn2; o_err = e2; o_wl = {15'd0, wl2}; end
      default: begin o_addr = {15'd0, a3}; o_wdata = d3; o_we = we3; o_busy = b3; o_done = dn3; o_err = e3; o_wl = {15'd0, wl3}; end
    endcase
  end

  typedef struct packed {
    logic [16:0] addr;
    logic [31:0] data;
  } wr_t;

  // Streams and expected words are right-aligned: the last byte/word is the LSB.
  typedef struct packed {
    int           sel;
    int           nb;
    logic [255:0] s;
    int           stop_mode;  // 0 none, 1 STOP after stream, 2 STOP with last byte
    int           gap;
    int           nw;
    logic [127:0] w;
    logic         exp_done;
    logic         exp_err;
    int           exp_wl;
  } vec_t;

  vec_t vecs [NV];
  wr_t  exp_q [$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input int sl, input int nb, input logic [255:0] s, input int sm,
                              input int gap, input int nw, input logic [127:0] w,
                              input logic ed, input logic ee, input int wl);
    vec_t r;
    r.sel = sl; r.nb = nb; r.s = s; r.stop_mode = sm; r.gap = gap;
    r.nw = nw; r.w = w; r.exp_done = ed; r.exp_err = ee; r.exp_wl = wl;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int addr, input logic [31:0] data);
    wr_t e;
    e.addr = 17'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Advance one clock, then check any memory write against the scoreboard.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    @(negedge clk);
    if (o_we) begin
      chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_addr", 64'(o_addr), 64'(e.addr));
        chk("write_data", 64'(o_wdata), 64'(e.data));
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stp);
    rx_data = b; rx_valid = 1'b1; stop = stp;
    tick();
    rx_valid = 1'b0; stop = 1'b0; rx_data = 8'h00;
  endtask

  task automatic send_str(input logic [255:0] s, input int nb, input logic stop_last, input int gap);
    for (int i = 0; i < nb; i++) begin
      send(s[8*(nb-1-i) +: 8], stop_last && (i == nb - 1));
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(0, 13, 256'h02000000_11223344_55667788_88, 0, 0, 2, 128'h44332211_88776655, 1'b1, 1'b0, 2);
    vecs[1]  = mk(0, 13, 256'h02000000_11223344_55667788_00, 0, 0, 2, 128'h44332211_88776655, 1'b0, 1'b1, 2);
    vecs[2]  = mk(1, 9, 256'h01000000_DEADBEEF_22, 0, 1, 1, 128'hDEADBEEF, 1'b1, 1'b0, 1);
    vecs[3]  = mk(2, 4, 256'h05000000, 0, 0, 0, 128'h0, 1'b0, 1'b1, 0);
    vecs[4]  = mk(3, 5, 256'h01020304_05, 1, 0, 2, 128'h04030201_00000005, 1'b1, 1'b0, 2);
    vecs[5]  = mk(0, 5, 256'h00000000_00, 0, 0, 0, 128'h0, 1'b1, 1'b0, 0);
    vecs[6]  = mk(2, 21, 256'h04000000_01020304_05060708_090A0B0C_0D0E0F10_10, 0, 0, 4,
                  128'h04030201_08070605_0C0B0A09_100F0E0D, 1'b1, 1'b0, 4);
    vecs[7]  = mk(3, 4, 256'h01020304, 2, 0, 1, 128'h04030201, 1'b1, 1'b0, 1);
    vecs[8]  = mk(3, 4, 256'hAABBCCDD, 1, 0, 1, 128'hDDCCBBAA, 1'b1, 1'b0, 1);
    vecs[9]  = mk(3, 20, 256'h01020304_05060708_090A0B0C_0D0E0F10_11121314, 0, 0, 4,
                  128'h04030201_08070605_0C0B0A09_100F0E0D, 1'b0, 1'b1, 4);
    vecs[10] = mk(1, 9, 256'h01000000_DEADBEEF_23, 0, 0, 1, 128'hDEADBEEF, 1'b0, 1'b1, 1);

    rst = 1'b1; start = 1'b0; stop = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; sel = 0;
    repeat (3) tick();
    rst = 1'b0;

    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      chk($sformatf("rst%0d_addr", s), 64'(o_addr), 64'd0);
      chk($sformatf("rst%0d_wdata", s), 64'(o_wdata), 64'd0);
      chk($sformatf("rst%0d_we", s), 64'(o_we), 64'd0);
      chk($sformatf("rst%0d_busy", s), 64'(o_busy), 64'd0);
      chk($sformatf("rst%0d_done", s), 64'(o_done), 64'd0);
      chk($sformatf("rst%0d_error", s), 64'(o_err), 64'd0);
      chk($sformatf("rst%0d_wl", s), 64'(o_wl), 64'd0);
    end

    for (int v = 0; v < NV; v++) begin
      sel = vecs[v].sel;
      exp_q.delete();
      for (int k = 0; k < vecs[v].nw; k++)
        push(k, vecs[v].w[32*(vecs[v].nw-1-k) +: 32]);
      pulse_start();
      chk($sformatf("v%0d_busy_after_start", v), 64'(o_busy), 64'd1);
      send_str(vecs[v].s, vecs[v].nb, vecs[v].stop_mode == 2, vecs[v].gap);
      if (vecs[v].stop_mode == 1) begin
        stop = 1'b1;
        tick();
        stop = 1'b0;
      end
      repeat (3) tick();
      chk($sformatf("v%0d_done", v), 64'(o_done), 64'(vecs[v].exp_done));
      chk($sformatf("v%0d_error", v), 64'(o_err), 64'(vecs[v].exp_err));
      chk($sformatf("v%0d_busy", v), 64'(o_busy), 64'd0);
      chk($sformatf("v%0d_words_loaded", v), 64'(o_wl), 64'(vecs[v].exp_wl));
      chk($sformatf("v%0d_pending_writes", v), 64'(exp_q.size()), 64'd0);
    end

    // Reset in the middle of the second word: only the first word is written.
    sel = 0;
    exp_q.delete();
    push(0, 32'h44332211);
    pulse_start();
    send_str(256'h03000000_11223344_5566, 10, 1'b0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_addr", 64'(o_addr), 64'd0);
    chk("midrst_wdata", 64'(o_wdata), 64'd0);
    chk("midrst_we", 64'(o_we), 64'd0);
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_done", 64'(o_done), 64'd0);
    chk("midrst_error", 64'(o_err), 64'd0);
    chk("midrst_wl", 64'(o_wl), 64'd0);
    chk("midrst_pending", 64'(exp_q.size()), 64'd0);

    // Restart after reset loads again from address 0.
    push(0, 32'h0D0C0B0A);
    pulse_start();
    send_str(256'h01000000_0A0B0C0D_00, 9, 1'b0, 0);
    repeat (2) tick();
    chk("restart_done", 64'(o_done), 64'd1);
    chk("restart_wl", 64'(o_wl), 64'd1);
    chk("restart_pending", 64'(exp_q.size()), 64'd0);

    // Bytes arriving in DONE are ignored; write port holds its last values.
    send_str(256'hABCDEF, 3, 1'b0, 0);
    tick();
    chk("hold_done", 64'(o_done), 64'd1);
    chk("hold_error", 64'(o_err), 64'd0);
    chk("hold_wl", 64'(o_wl), 64'd1);
    chk("hold_we", 64'(o_we), 64'd0);
    chk("hold_addr", 64'(o_addr), 64'd0);
    chk("hold_wdata", 64'(o_wdata), 64'h0D0C0B0A);

    // START mid-word discards the partial word; STOP is ignored in framed mode.
    pulse_start();
    chk("restart2_busy", 64'(o_busy), 64'd1);
    chk("restart2_done", 64'(o_done), 64'd0);
    chk("restart2_wl", 64'(o_wl), 64'd0);
    send_str(256'h01000000_1122, 6, 1'b0, 0);
    pulse_start();
    push(0, 32'h44332211);
    send_str(256'h01000000_11, 5, 1'b0, 0);
    send(8'h22, 1'b1);
    send_str(256'h33_44_44, 3, 1'b0, 0);
    repeat (2) tick();
    chk("midstart_done", 64'(o_done), 64'd1);
    chk("midstart_error", 64'(o_err), 64'd0);
    chk("midstart_wl", 64'(o_wl), 64'd1);
    chk("midstart_pending", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
